// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with a destination-register scoreboard.
// Two write-back requesters (vector ALU lane, memory load unit) share one
// registered write port under round-robin priority. An 8-entry busy vector
// tracks registers that have a write-back pending, so the issue stage can
// stall instead of creating a write-after-write hazard.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [2:0]       req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [2:0]       req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,

    input  logic             rsv_valid,
    input  logic [2:0]       rsv_addr,
    output logic             rsv_ready,

    output logic [7:0]       busy,
    output logic             we,
    output logic [2:0]       wr_addr,
    output logic [WIDTH-1:0] wr_data
);

    // Index of the requester granted most recently; the other one wins a tie.
    logic             last_grant_q, last_grant_d;
    logic [7:0]       busy_q, busy_d;
    logic             we_q, we_d;
    logic [2:0]       wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    logic             grant0, grant1;
    logic             xfer;
    logic             rsv_accept;

    // Round-robin grants and reservation handshake, all masked while in reset.
    always_comb begin
        grant0     = !rst && req0_valid && (!req1_valid || last_grant_q);
        grant1     = !rst && req1_valid && (!req0_valid || !last_grant_q);
        xfer       = grant0 || grant1;
        rsv_accept = !rst && rsv_valid && !busy_q[rsv_addr];
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsv_ready  = rsv_accept;

    // Next-state logic for the write port, priority pointer and scoreboard.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        we_d         = xfer;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (grant0) begin
            last_grant_d = 1'b0;
            wr_addr_d    = req0_addr;
            wr_data_d    = req0_data;
        end else if (grant1) begin
            last_grant_d = 1'b1;
            wr_addr_d    = req1_addr;
            wr_data_d    = req1_data;
        end

        // Clear first, then set: a reservation at the same edge keeps the bit.
        if (xfer) begin
            busy_d[wr_addr_d] = 1'b0;
        end
        if (rsv_accept) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // State registers; reset forces req0 to win the first contest.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            last_grant_q <= 1'b1;
            busy_q       <= 8'h00;
            we_q         <= 1'b0;
            wr_addr_q    <= 3'd0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign we      = we_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with hand-computed
// expectations for grants, the registered write port and the busy scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rsv_valid;
    logic [2:0]  rsv_addr;
    logic        rsv_ready;
    logic [7:0]  busy;
    logic        we;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_passed = 0;

    regfile_wb_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ready  (rsv_ready),
        .busy       (busy),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsv_valid  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    logic exp_g0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 3'd0;
        req0_data  = 32'h0;
        req1_valid = 1'b1;
        req1_addr  = 3'd0;
        req1_data  = 32'h0;
        rsv_valid  = 1'b1;
        rsv_addr   = 3'd0;

        // Reset state: readies masked even with all valids high.
        #12;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsv_ready",  32'(rsv_ready),  32'd0);
        check("rst_we",         32'(we),         32'd0);
        check("rst_wr_addr",    32'(wr_addr),    32'd0);
        check("rst_wr_data",    wr_data,         32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;

        // Single request, 1-cycle write latency, hold on idle.
        req0_valid = 1'b1;
        req0_addr  = 3'd3;
        req0_data  = 32'hAAAA_0001;
        #1;
        check("single_req0_ready", 32'(req0_ready), 32'd1);
        check("single_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("single_we",      32'(we),      32'd1);
        check("single_wr_addr", 32'(wr_addr), 32'd3);
        check("single_wr_data", wr_data,      32'hAAAA_0001);
        tick();
        check("idle_we",      32'(we),      32'd0);
        check("idle_wr_addr", 32'(wr_addr), 32'd3);
        check("idle_wr_data", wr_data,      32'hAAAA_0001);

        // Round-robin alternation from a fresh reset.
        pulse_reset();
        req0_valid = 1'b1;
        req0_addr  = 3'd1;
        req0_data  = 32'h0000_0011;
        req1_valid = 1'b1;
        req1_addr  = 3'd2;
        req1_data  = 32'h0000_0022;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr%0d_req0_ready", i), 32'(req0_ready), 32'(exp_g0[i]));
            check($sformatf("rr%0d_req1_ready", i), 32'(req1_ready), 32'(!exp_g0[i]));
            tick();
            check($sformatf("rr%0d_we", i),      32'(we),      32'd1);
            check($sformatf("rr%0d_wr_addr", i), 32'(wr_addr), exp_g0[i] ? 32'd1 : 32'd2);
            check($sformatf("rr%0d_wr_data", i), wr_data,      exp_g0[i] ? 32'h11 : 32'h22);
        end
        idle_inputs();

        // Reservation, WAW stall, clear on write-back.
        rsv_valid = 1'b1;
        rsv_addr  = 3'd5;
        #1;
        check("rsv5_ready", 32'(rsv_ready), 32'd1);
        tick();
        check("rsv5_busy", 32'(busy), 32'h20);
        #1;
        check("rsv5_again_ready", 32'(rsv_ready), 32'd0);
        tick();
        check("rsv5_again_busy", 32'(busy), 32'h20);
        rsv_valid  = 1'b0;
        req1_valid = 1'b1;
        req1_addr  = 3'd5;
        req1_data  = 32'h0000_0055;
        #1;
        check("wb5_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("wb5_we",      32'(we),      32'd1);
        check("wb5_wr_addr", 32'(wr_addr), 32'd5);
        check("wb5_busy",    32'(busy),    32'h00);

        // Same-edge set/clear on register 4.
        rsv_valid = 1'b1;
        rsv_addr  = 3'd4;
        tick();
        check("rsv4_busy", 32'(busy), 32'h10);
        req0_valid = 1'b1;
        req0_addr  = 3'd4;
        req0_data  = 32'h0000_0044;
        #1;
        check("rsv4_blocked_ready", 32'(rsv_ready),  32'd0);
        check("wb4_req0_ready",     32'(req0_ready), 32'd1);
        tick();
        check("wb4_clear_busy", 32'(busy), 32'h00);
        #1;
        check("rsv4_accept_ready", 32'(rsv_ready), 32'd1);
        tick();
        check("set_wins_busy", 32'(busy), 32'h10);
        check("set_wins_we",   32'(we),   32'd1);
        req0_valid = 1'b0;

        // Fill the scoreboard, last edge also writes back req0 (pointer -> 0).
        for (int i = 0; i < 8; i++) begin
            if (i != 4) begin
                rsv_valid = 1'b1;
                rsv_addr  = 3'(i);
                if (i == 7) begin
                    req0_valid = 1'b1;
                    req0_addr  = 3'd7;
                    req0_data  = 32'h0000_0077;
                end
                tick();
            end
        end
        idle_inputs();
        check("full_busy", 32'(busy), 32'hFF);
        check("full_we",   32'(we),   32'd1);

        // Asynchronous reset mid-cycle.
        #2;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 3'd6;
        req1_valid = 1'b1;
        req1_addr  = 3'd2;
        rsv_valid  = 1'b1;
        #1;
        check("async_we",         32'(we),         32'd0);
        check("async_busy",       32'(busy),       32'h00);
        check("async_wr_addr",    32'(wr_addr),    32'd0);
        check("async_req0_ready", 32'(req0_ready), 32'd0);
        check("async_req1_ready", 32'(req1_ready), 32'd0);
        check("async_rsv_ready",  32'(rsv_ready),  32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        check("post_rst_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        check("post_rst_wr_addr", 32'(wr_addr), 32'd6);
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of the register file write port.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  write-back request from vector ALU lane.
REQ-005 req0_addr  input  3  destination register of req0.
REQ-006 req0_data  input  WIDTH  write data of req0.
REQ-007 req0_ready  output  1  req0 granted this cycle.
REQ-008 req1_valid  input  1  write-back request from memory load unit.
REQ-009 req1_addr  input  3  destination register of req1.
REQ-010 req1_data  input  WIDTH  write data of req1.
REQ-011 req1_ready  output  1  req1 granted this cycle.
REQ-012 rsv_valid  input  1  issue stage requests to reserve a destination register.
REQ-013 rsv_addr  input  3  register to reserve.
REQ-014 rsv_ready  output  1  reservation accepted this cycle.
REQ-015 busy  output  8  per-register pending-write flags, bit n = register n.
REQ-016 we  output  1  register file write enable.
REQ-017 wr_addr  output  3  register file write address.
REQ-018 wr_data  output  WIDTH  register file write data.

Function
REQ-019 Transfer on requester i = reqi_valid & reqi_ready at a rising clk edge.
REQ-020 reqi_ready is combinational from the valid inputs and the priority pointer; it does not depend on reqi_ready of the other port.
REQ-021 Only one requester valid: that requester is granted (ready=1) in the same cycle.
REQ-022 Both valid: the requester other than the last-granted one is granted; the other sees ready=0.
REQ-023 Priority pointer (last_grant, 1 bit) updates to the granted index on every transfer; it is unchanged when there is no transfer.
REQ-024 At most one of req0_ready/req1_ready is 1 in any cycle; neither is 1 while its valid is 0.
REQ-025 Requesters hold valid, addr and data stable until they are granted; the block does not check this.
REQ-026 Write port is registered, 1-cycle latency: on the edge of a transfer, we<=1, wr_addr<=granted addr, wr_data<=granted data.
REQ-027 On an edge without a transfer: we<=0; wr_addr and wr_data hold their previous values.
REQ-028 Outputs are stable for a full clk period, so the register file samples them on the following falling edge.
REQ-029 rsv_ready = rsv_valid & ~busy[rsv_addr] (combinational); reserving an already-busy register stalls the issue stage (prevents WAW).
REQ-030 Accepted reservation (rsv_valid & rsv_ready) sets busy[rsv_addr] at the edge.
REQ-031 A transfer to address a clears busy[a] at the same edge at which we rises.
REQ-032 Set and clear of the same bit at one edge: set wins and the bit stays 1.
REQ-033 A transfer to a non-busy register is legal; busy stays 0 for that register.
REQ-034 Arbitration and the scoreboard are independent; a grant never waits on busy.

Reset
REQ-035 While rst=1, asynchronously: we=0, wr_addr=0, wr_data=0, busy=8'h00, last_grant=1 (req0 wins the first contest).
REQ-036 While rst=1, req0_ready=0, req1_ready=0 and rsv_ready=0, regardless of the valid inputs.
REQ-037 Reset mid-operation discards a captured but unwritten write (we forced 0) and clears all reservations; the first edge after rst falls behaves as after power-up.

Verification
REQ-038 After reset, req0 valid addr=3 data=0xAAAA_0001 alone -> req0_ready=1 same cycle; next cycle we=1, wr_addr=3, wr_data=0xAAAA_0001; following idle cycle we=0, wr_addr/wr_data held.
REQ-039 Both valid continuously for 4 cycles after reset (req0 addr=1, req1 addr=2) -> grants alternate req0, req1, req0, req1; wr_addr sequence 1,2,1,2.
REQ-040 rsv_valid addr=5 -> busy=8'h20; second rsv addr=5 -> rsv_ready=0; req1 write addr=5 -> busy=8'h00 on the same edge we=1.
REQ-041 busy[4]=1; same edge: rsv addr=4 with rsv_ready low (expect no set), then after clear, same-edge rsv addr=4 accepted and req0 transfer addr=4 -> busy[4]=1 (set wins).
REQ-042 rst asserted asynchronously mid-cycle with we=1 and busy=8'hFF -> we=0, busy=0 immediately; after release, a contest grants req0 first.
